kernel_rst_seq: RTL and testbench

Reset sequencer sitting directly upstream of the Nios kernel's `reset_reset_n` input, in the `nios_clk` domain behind the PLL. It combines the board reset button (debounced) and the PLL `locked` flag (qualified) into one clean, glitch-free, active-low kernel reset. The kernel is released only after a guaranteed hold period, and is re-reset on lock loss or a button press. It also records the cause and count of reset events for software and debug.

---
 rtl/kernel_rst_seq_pkg.sv | 24 ++
 rtl/kernel_rst_seq_if.sv | 18 +
 rtl/kernel_rst_seq_sync_filter.sv | 56 +++++
 rtl/kernel_rst_seq.sv | 97 +++++++++
 tb/tb_kernel_rst_seq.sv | 136 +++++++++++++
 5 files changed

// File: rtl/kernel_rst_seq_pkg.sv
// Shared types and helpers for the Nios kernel reset sequencer.
package kernel_rst_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_BTN  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  function automatic logic [1:0] exit_cause(input logic lock_level, input logic btn_level);
    return {~lock_level, ~btn_level};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/kernel_rst_seq_if.sv
// Board-side inputs and status outputs of the kernel reset sequencer.
interface kernel_rst_seq_if;
  logic       btn_rst_n;
  logic       pll_locked;
  logic       kernel_rst_n;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  modport master (
    output btn_rst_n, pll_locked,
    input  kernel_rst_n, rst_cause, rst_count
  );

  modport slave (
    input  btn_rst_n, pll_locked,
    output kernel_rst_n, rst_cause, rst_count
  );
endinterface

// File: rtl/kernel_rst_seq_sync_filter.sv
// Two-flop synchronizer followed by a stable-count filter; with FILTER_FALL=0
// only rising edges are filtered and a low input drops the output at once.
module sync_filter #(
  parameter int unsigned CYCLES      = 1,
  parameter bit          FILTER_FALL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic filt_o,
  output logic live_o
);

  localparam int unsigned     CW   = $clog2(CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = {CW{1'b0}};
    if (sync_q == filt_q) begin
      cnt_d = {CW{1'b0}};
    end else if (!FILTER_FALL && !sync_q) begin
      filt_d = 1'b0;
    end else if (cnt_q == LAST) begin
      filt_d = sync_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign filt_o = filt_q;
  // The level a running kernel watches: unfiltered falls bypass the counter.
  assign live_o = FILTER_FALL ? filt_q : sync_q;

endmodule

// File: rtl/kernel_rst_seq.sv
// Reset sequencer feeding the Nios kernel: debounced button plus qualified PLL
// lock gate a held-off, registered active-low kernel reset with cause/count status.
module kernel_rst_seq
  import kernel_rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES    = 50000,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned HOLD_CYCLES        = 1024
) (
  input logic             clk,
  input logic             rst,
  kernel_rst_seq_if.slave bus
);

  localparam int unsigned   HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          btn_db;
  logic          btn_live;
  logic          lock_ok;
  logic          lock_live;
  state_e        state_q;
  state_e        state_d;
  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          run_exit;
  logic          krn_q;
  logic [1:0]    cause_q;
  logic [7:0]    count_q;

  sync_filter #(.CYCLES(DEBOUNCE_CYCLES), .FILTER_FALL(1'b1)) u_btn (
    .clk(clk), .rst(rst), .async_i(bus.btn_rst_n), .filt_o(btn_db), .live_o(btn_live)
  );

  sync_filter #(.CYCLES(LOCK_STABLE_CYCLES), .FILTER_FALL(1'b0)) u_lock (
    .clk(clk), .rst(rst), .async_i(bus.pll_locked), .filt_o(lock_ok), .live_o(lock_live)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    run_exit = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_WAIT;
      ST_WAIT: begin
        if (lock_ok && btn_db) begin
          state_d = ST_HOLD;
          hold_d  = {HW{1'b0}};
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (!lock_ok || !btn_db) begin
          state_d = ST_WAIT;
        end else if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_live || !btn_live) begin
          state_d  = ST_WAIT;
          run_exit = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  // kernel_rst_n is loaded from the next state so it is high exactly while in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
      hold_q  <= {HW{1'b0}};
      krn_q   <= 1'b0;
      cause_q <= CAUSE_NONE;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      krn_q   <= (state_d == ST_RUN);
      if (run_exit) begin
        cause_q <= exit_cause(lock_live, btn_live);
        count_q <= sat_inc8(count_q);
      end
    end
  end

  assign bus.kernel_rst_n = krn_q;
  assign bus.rst_cause    = cause_q;
  assign bus.rst_count    = count_q;

endmodule

// File: tb/tb_kernel_rst_seq.sv
// Directed vector bench for kernel_rst_seq with small debounce/lock/hold counts.
module tb_kernel_rst_seq;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       lock;
    int         n;
    logic       krn;
    logic [1:0] cause;
    logic [7:0] count;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   split_at;
  vec_t vecs[$];

  kernel_rst_seq_if bus ();

  kernel_rst_seq #(
    .DEBOUNCE_CYCLES(4), .LOCK_STABLE_CYCLES(8), .HOLD_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic b, input logic l, input int n,
                              input logic k, input logic [1:0] c, input logic [7:0] cnt);
    vec_t v;
    v.rst = r; v.btn = b; v.lock = l; v.n = n; v.krn = k; v.cause = c; v.count = cnt;
    vecs.push_back(v);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string what, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", what, idx, act, exp);
    end
  endtask

  task automatic apply(input int idx);
    rst = vecs[idx].rst;
    bus.btn_rst_n  = vecs[idx].btn;
    bus.pll_locked = vecs[idx].lock;
    tick(vecs[idx].n);
    check("kernel_rst_n", idx, {7'd0, bus.kernel_rst_n}, {7'd0, vecs[idx].krn});
    check("rst_cause", idx, {6'd0, bus.rst_cause}, {6'd0, vecs[idx].cause});
    check("rst_count", idx, bus.rst_count, vecs[idx].count);
  endtask

  initial begin
    logic [7:0] exp_count;
    clk = 1'b0;
    rst = 1'b1;
    bus.btn_rst_n  = 1'b0;
    bus.pll_locked = 1'b0;
    checks = 0;
    errors = 0;

    // reset, power-up release after edge 26
    add(1'b1, 1'b0, 1'b0, 3,  1'b0, 2'b00, 8'd0);
    add(1'b0, 1'b1, 1'b1, 26, 1'b0, 2'b00, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1,  1'b1, 2'b00, 8'd0);
    add(1'b0, 1'b1, 1'b1, 10, 1'b1, 2'b00, 8'd0);
    // lock loss in RUN: low after edge 2
    add(1'b0, 1'b1, 1'b0, 2,  1'b1, 2'b00, 8'd0);
    add(1'b0, 1'b1, 1'b0, 1,  1'b0, 2'b10, 8'd1);
    // lock chatter: 5 high, 1 low, then release 26 edges after final rise
    add(1'b0, 1'b1, 1'b1, 5,  1'b0, 2'b10, 8'd1);
    add(1'b0, 1'b1, 1'b0, 1,  1'b0, 2'b10, 8'd1);
    add(1'b0, 1'b1, 1'b1, 26, 1'b0, 2'b10, 8'd1);
    add(1'b0, 1'b1, 1'b1, 1,  1'b1, 2'b10, 8'd1);
    // 3-cycle button glitch is rejected
    add(1'b0, 1'b0, 1'b1, 3,  1'b1, 2'b10, 8'd1);
    add(1'b0, 1'b1, 1'b1, 10, 1'b1, 2'b10, 8'd1);
    // 10-cycle press: low after edge 6, then re-release
    add(1'b0, 1'b0, 1'b1, 6,  1'b1, 2'b10, 8'd1);
    add(1'b0, 1'b0, 1'b1, 1,  1'b0, 2'b01, 8'd2);
    add(1'b0, 1'b0, 1'b1, 3,  1'b0, 2'b01, 8'd2);
    add(1'b0, 1'b1, 1'b1, 22, 1'b0, 2'b01, 8'd2);
    add(1'b0, 1'b1, 1'b1, 1,  1'b1, 2'b01, 8'd2);
    // lock loss lands on the same edge as the debounced press
    add(1'b0, 1'b0, 1'b1, 4,  1'b1, 2'b01, 8'd2);
    add(1'b0, 1'b0, 1'b0, 2,  1'b1, 2'b01, 8'd2);
    add(1'b0, 1'b0, 1'b0, 1,  1'b0, 2'b11, 8'd3);
    add(1'b0, 1'b1, 1'b1, 26, 1'b0, 2'b11, 8'd3);
    add(1'b0, 1'b1, 1'b1, 1,  1'b1, 2'b11, 8'd3);
    // abort from HOLD leaves cause and count untouched
    add(1'b0, 1'b1, 1'b0, 3,  1'b0, 2'b10, 8'd4);
    add(1'b0, 1'b1, 1'b1, 14, 1'b0, 2'b10, 8'd4);
    add(1'b0, 1'b1, 1'b0, 5,  1'b0, 2'b10, 8'd4);
    split_at = vecs.size();
    // rst mid-HOLD after saturation, then a fresh release
    add(1'b0, 1'b1, 1'b1, 14, 1'b0, 2'b10, 8'd255);
    add(1'b1, 1'b1, 1'b1, 1,  1'b0, 2'b00, 8'd0);
    add(1'b0, 1'b1, 1'b1, 26, 1'b0, 2'b00, 8'd0);
    add(1'b0, 1'b1, 1'b1, 1,  1'b1, 2'b00, 8'd0);

    for (int i = 0; i < split_at; i++) begin
      apply(i);
    end

    exp_count = 8'd4;
    for (int i = 0; i < 260; i++) begin
      bus.pll_locked = 1'b1;
      tick(27);
      check("sat_release", i, {7'd0, bus.kernel_rst_n}, 8'd1);
      bus.pll_locked = 1'b0;
      tick(3);
      if (exp_count != 8'd255) exp_count = exp_count + 8'd1;
      check("sat_drop", i, {7'd0, bus.kernel_rst_n}, 8'd0);
      check("sat_count", i, bus.rst_count, exp_count);
    end
    check("sat_cause", 0, {6'd0, bus.rst_cause}, 8'd2);

    for (int i = split_at; i < vecs.size(); i++) begin
      apply(i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
